fetch_controller: RTL and testbench

//  Sequences the word-addressed, synchronous-read instruction memory (imem). Owns the program counter and

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_controller.sv | 112 +++++++++++
 tb/tb_fetch_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================
// Module  : fetch_pkg
// Brief   : shared types, widths and PC wrap helper for the fetch unit
// Rev     : 1.0
// ============================================================
package fetch_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    localparam int unsigned c_ADDR_W = 32;
    localparam int unsigned c_DATA_W = 32;

    // depth is a power of two, so the modulo is a mask
    function automatic logic [31:0] wrap_pc(input logic [31:0] pc, input int unsigned depth);
        return pc & (depth - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================
// Module  : fetch_queue
// Brief   : two-entry FIFO of {pc, instr}; head holds its last value when emptied
// Rev     : 1.0
// ============================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = c_ADDR_W + c_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;

    // Shift-style storage: the head register is the output, so popping the
    // last entry leaves its contents visible instead of stale slot data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (push) begin
                        r_head  <= push_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        r_head <= push_data;
                    end else if (push) begin
                        r_tail  <= push_data;
                        r_count <= 2'd2;
                    end else if (pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        r_head <= r_tail;
                        if (push) begin
                            r_tail <= push_data;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign head  = r_head;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================
// Module  : fetch_controller
// Brief   : PC sequencing, imem addressing and credit-based queueing toward decode
// Rev     : 1.0
// ============================================================
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = c_ADDR_W,
    parameter int unsigned       DATA_W   = c_DATA_W,
    parameter int unsigned       DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy
);

    localparam int unsigned c_ENTRY_W = ADDR_W + DATA_W;

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [1:0]        w_count;
    logic [2:0]        w_occupancy;
    logic [c_ENTRY_W-1:0] w_head;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (run)  w_state_next = FETCH;
            FETCH: if (!run) w_state_next = IDLE;
        endcase
    end

    // A transfer shown during a redirect is discarded along with the flush.
    assign w_pop       = out_valid & out_ready & ~redirect_valid;
    assign w_push      = r_inflight & ~redirect_valid;
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight};

    // Credit: every issued word already owns a queue slot when it lands.
    // run gates issue directly so a stop takes effect in the same cycle.
    assign w_issue = (r_state == FETCH) & run & ~redirect_valid &
                     (w_occupancy < (3'(QDEPTH) + {2'b00, w_pop}));

    assign w_pc_inc      = ADDR_W'(wrap_pc(32'(r_pc) + 32'd1, DEPTH));
    assign w_redirect_pc = ADDR_W'(wrap_pc(32'(redirect_pc), DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_issue) begin
                r_pc          <= w_pc_inc;
                r_inflight_pc <= r_pc;
            end
        end
    end

    fetch_queue #(
        .WIDTH (c_ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data ({r_inflight_pc, imem_instr}),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    assign imem_addr = r_pc;
    assign out_valid = (w_count != 2'd0);
    assign out_pc    = w_head[c_ENTRY_W-1 -: ADDR_W];
    assign out_instr = w_head[DATA_W-1:0];
    assign busy      = (r_state == FETCH) | r_inflight | (w_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================
// Module  : tb_fetch_controller
// Brief   : directed table-driven bench for fetch_controller with a preloaded imem
// Rev     : 1.0
// ============================================================
module tb_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [8];

    typedef struct {
        logic        run;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic        cd;
        logic [31:0] epc;
        logic [31:0] ein;
        logic [31:0] eaddr;
        logic        ebusy;
    } vec_t;

    vec_t vecs [32];

    fetch_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory
    initial imem_instr = '0;
    always @(posedge clk) imem_instr <= mem[imem_addr[2:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // The credit rule must never let a push land on a full, non-draining queue
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("queue overflow",
                  {31'b0, dut.r_inflight & ~redirect_valid & (dut.w_count == 2'd2) &
                          ~(out_valid & out_ready)},
                  32'd0);
        end
    end

    task automatic set_row(input int i, input logic r, input logic rd, input logic rv,
                           input logic [31:0] rpc, input logic ev, input logic cd,
                           input logic [31:0] epc, input logic [31:0] ein,
                           input logic [31:0] eaddr, input logic ebusy);
        vecs[i] = '{r, rd, rv, rpc, ev, cd, epc, ein, eaddr, ebusy};
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            run            = vecs[i].run;
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            check($sformatf("row%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
            check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].eaddr);
            check($sformatf("row%0d busy", i), {31'b0, busy}, {31'b0, vecs[i].ebusy});
            if (vecs[i].cd) begin
                check($sformatf("row%0d out_pc", i), out_pc, vecs[i].epc);
                check($sformatf("row%0d out_instr", i), out_instr, vecs[i].ein);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'(10 * (i + 1));

        //          idx run rdy rv rpc           ev cd pc ins addr busy
        // start, first word at cycle 3, then wrap 7 -> 0
        set_row( 0, 1, 1, 0, 32'd0,          0, 1, 0,  0, 0, 0);
        set_row( 1, 1, 1, 0, 32'd0,          0, 1, 0,  0, 0, 1);
        set_row( 2, 1, 1, 0, 32'd0,          0, 1, 0,  0, 1, 1);
        set_row( 3, 1, 1, 0, 32'd0,          1, 1, 0, 10, 2, 1);
        set_row( 4, 1, 1, 0, 32'd0,          1, 1, 1, 20, 3, 1);
        set_row( 5, 1, 1, 0, 32'd0,          1, 1, 2, 30, 4, 1);
        set_row( 6, 1, 1, 0, 32'd0,          1, 1, 3, 40, 5, 1);
        set_row( 7, 1, 1, 0, 32'd0,          1, 1, 4, 50, 6, 1);
        set_row( 8, 1, 1, 0, 32'd0,          1, 1, 5, 60, 7, 1);
        set_row( 9, 1, 1, 0, 32'd0,          1, 1, 6, 70, 0, 1);
        set_row(10, 1, 1, 0, 32'd0,          1, 1, 7, 80, 1, 1);
        set_row(11, 1, 1, 0, 32'd0,          1, 1, 0, 10, 2, 1);
        // decode stalls 5 cycles: everything frozen
        set_row(12, 1, 0, 0, 32'd0,          1, 1, 1, 20, 3, 1);
        set_row(13, 1, 0, 0, 32'd0,          1, 1, 1, 20, 3, 1);
        set_row(14, 1, 0, 0, 32'd0,          1, 1, 1, 20, 3, 1);
        set_row(15, 1, 0, 0, 32'd0,          1, 1, 1, 20, 3, 1);
        set_row(16, 1, 0, 0, 32'd0,          1, 1, 1, 20, 3, 1);
        set_row(17, 1, 1, 0, 32'd0,          1, 1, 1, 20, 3, 1);
        set_row(18, 1, 1, 0, 32'd0,          1, 1, 2, 30, 4, 1);
        set_row(19, 1, 1, 0, 32'd0,          1, 1, 3, 40, 5, 1);
        set_row(20, 1, 1, 0, 32'd0,          1, 1, 4, 50, 6, 1);
        // fill the queue, then redirect to 5 (upper bits must be masked)
        set_row(21, 1, 0, 0, 32'd0,          1, 1, 5, 60, 7, 1);
        set_row(22, 1, 0, 0, 32'd0,          1, 1, 5, 60, 7, 1);
        set_row(23, 1, 1, 1, 32'hFFFF_FFF5,  1, 1, 5, 60, 7, 1);
        set_row(24, 1, 1, 0, 32'd0,          0, 0, 0,  0, 5, 1);
        set_row(25, 1, 1, 0, 32'd0,          0, 0, 0,  0, 6, 1);
        set_row(26, 1, 1, 0, 32'd0,          1, 1, 5, 60, 7, 1);
        set_row(27, 1, 1, 0, 32'd0,          1, 1, 6, 70, 0, 1);
        // stop with one queued and one in flight: two transfers, then idle
        set_row(28, 0, 1, 0, 32'd0,          1, 1, 7, 80, 1, 1);
        set_row(29, 0, 1, 0, 32'd0,          1, 1, 0, 10, 1, 1);
        set_row(30, 0, 1, 0, 32'd0,          0, 1, 0, 10, 1, 0);
        set_row(31, 0, 1, 0, 32'd0,          0, 1, 0, 10, 1, 0);

        rst_n          = 1'b0;
        run            = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_pc", out_pc, 32'd0);
        check("reset out_instr", out_instr, 32'd0);
        check("reset imem_addr", imem_addr, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;

        apply_rows(0, 31);

        // Restart from PC 1, then pull reset asynchronously mid-stream
        run       = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("restart out_valid", {31'b0, out_valid}, 32'd1);
        check("restart out_pc", out_pc, 32'd2);
        check("restart out_instr", out_instr, 32'd30);
        check("restart imem_addr", imem_addr, 32'd4);
        #3;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst busy", {31'b0, busy}, 32'd0);
        check("async rst imem_addr", imem_addr, 32'd0);
        check("async rst out_pc", out_pc, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        apply_rows(0, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
